div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Sequencing controller for the shared iterative 32-bit divider in the EXE stage.
- Accepts one div.w / mod.w / div.wu / mod.wu request at a time from EXE through a valid/ready handshake.
- Runs a 32-step restoring division on operand magnitudes, fixes up signs, and holds the result until EXE acknowledges it.
- EXE uses `div_busy` to stall itself while a division is in flight; `div_cancel` aborts the operation on a pipeline flush.

Parameters:
- XLEN, 32, operand/result width.
- STEPS, 32, number of iteration cycles; must equal XLEN.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- div_req  input  1  request valid from EXE.
- div_op  input  4  one-hot request type {div_w, mod_w, div_wu, mod_wu}, bit 3 = div_w.
- div_src1  input  XLEN  dividend (rj value).
- div_src2  input  XLEN  divisor (rk value).
- div_ready  output  1  controller can accept a request this cycle.
- div_cancel  input  1  flush: abort any in-flight or completed operation.
- res_valid  output  1  result available.
- res_ack  input  1  EXE consumes the result this cycle.
- div_result  output  XLEN  quotient or remainder, as selected by div_op.
- div_busy  output  1  a request is held and not yet consumed (CALC or DONE).

Behaviour:
- Clocking and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: state = IDLE, `div_ready` = 1, `res_valid` = 0, `div_busy` = 0, `div_result` = 0, step counter = 0.
- FSM states: IDLE, CALC, DONE.
- Accept: handshake fires when `div_req & div_ready`; `div_ready` = 1 only in IDLE.
  - On accept, latch: |src1|, |src2|, op type, quotient sign and remainder sign.
  - For signed ops, magnitude = two's-complement negate when bit 31 = 1.
  - For unsigned ops, magnitude = raw value.
  - Quotient sign = src1[31] ^ src2[31] (signed ops only). Remainder sign = src1[31] (signed ops only).
- IDLE -> CALC on accept with a nonzero divisor.
- IDLE -> DONE on accept with divisor == 0 (fast path, no iteration). Forced result:
  - div: quotient 0xFFFFFFFF.
  - mod: remainder = raw src1.
- CALC: one restoring step per cycle on a 33-bit partial remainder.
  - Each step: shift in the next dividend MSB, trial-subtract the divisor, and set the quotient bit when the difference is non-negative.
  - The counter runs 0..31; CALC -> DONE after the step with counter == 31.
- DONE entry: apply the sign fix-up and the quotient/remainder select, then register `div_result`.
- Output timing:
  - `res_valid` = 1 and `div_result` are stable for the whole of DONE.
  - Nonzero-divisor latency: request accepted at cycle T, `res_valid` first high at T+33.
  - Zero-divisor latency: `res_valid` at T+1.
- DONE -> IDLE on `res_ack`; `div_ready` is high the following cycle.
- `res_ack` outside DONE is ignored.
- No back-to-back overlap: a request presented during CALC or DONE is not accepted and must be held by EXE.
- `div_busy` = (state != IDLE).
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0. This falls out of the magnitude algorithm; no special case.
- `div_cancel` (any state): next cycle state = IDLE, `res_valid` = 0, counter = 0, and any result is discarded.
  - `div_cancel` takes priority over `res_ack` and over `div_req` in the same cycle; no accept that cycle.
- `reset` mid-operation behaves identically to `div_cancel` and additionally clears `div_result`.

Test Plan:
- div_w 100 / 7, accepted at T → `res_valid` rises at T+33 with `div_result` = 14. `res_ack` at T+33 → `div_ready` = 1 at T+34.
- mod_w 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFF (−1). div_w with the same operands → 0xFFFFFFFD (−3).
- div_wu 0xFFFFFFFF / 2 → 0x7FFFFFFF. mod_wu 0xFFFFFFFF / 2 → 1.
- div_w 5 / 0 → `res_valid` at T+1 with 0xFFFFFFFF. mod_wu 5 / 0 → 5 at T+1. div_w 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+33.
- `div_cancel` pulsed 10 cycles into CALC → IDLE next cycle with `res_valid` never asserted. A new div_w 9 / 3 is accepted the following cycle → 3.
- `res_ack` held low for 5 cycles in DONE while `div_req` is high with new operands → `div_result` is held stable, `div_ready` = 0, no accept. The new request is accepted the cycle after `res_ack`.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing controller for the shared iterative restoring divider
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_req,
  input  logic [3:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  output logic            div_ready,
  input  logic            div_cancel,
  output logic            res_valid,
  input  logic            res_ack,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy
);
  localparam int CW = $clog2(STEPS);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] quo, dvs, rem;
  logic op_div, q_neg, r_neg;
  logic in_signed, in_div, src2_zero, accept, last;
  logic [XLEN-1:0] mag1, mag2, zero_res, rem_nx, quo_nx, calc_res;
  logic [XLEN:0] shifted, diff;
  assign in_signed = div_op[3] | div_op[2];
  assign in_div    = (div_op[3] | div_op[1]) & ~(div_op[2] | div_op[0]);
  assign src2_zero = div_src2 == '0;
  assign mag1      = (in_signed & div_src1[XLEN-1]) ? -div_src1 : div_src1;
  assign mag2      = (in_signed & div_src2[XLEN-1]) ? -div_src2 : div_src2;
  assign zero_res  = in_div ? '1 : div_src1;
  assign accept    = div_req & div_ready & ~div_cancel;
  assign last      = cnt == CW'(STEPS - 1);
  // one restoring step: shift in the next dividend bit, trial-subtract, keep on non-negative
  assign shifted   = {rem, quo[XLEN-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign rem_nx    = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nx    = {quo[XLEN-2:0], ~diff[XLEN]};
  assign calc_res  = op_div ? (q_neg ? -quo_nx : quo_nx) : (r_neg ? -rem_nx : rem_nx);
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state; cancel overrides both ack and a new request
  always_comb begin
    state_nx = state;
    if (div_cancel) state_nx = IDLE;
    else if (state == IDLE && div_req) state_nx = src2_zero ? DONE : CALC;
    else if (state == CALC && last) state_nx = DONE;
    else if (state == DONE && res_ack) state_nx = IDLE;
  end
  // handshake and status outputs decoded from state
  always_comb begin
    div_ready = state == IDLE;
    res_valid = state == DONE;
    div_busy  = state != IDLE;
  end
  // operand latch, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      quo        <= '0;
      dvs        <= '0;
      rem        <= '0;
      op_div     <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_result <= '0;
    end else if (div_cancel) begin
      cnt <= '0;
    end else if (accept) begin
      cnt    <= '0;
      quo    <= mag1;
      dvs    <= mag2;
      rem    <= '0;
      op_div <= in_div;
      q_neg  <= in_signed & (div_src1[XLEN-1] ^ div_src2[XLEN-1]);
      r_neg  <= in_signed & div_src1[XLEN-1];
      if (src2_zero) div_result <= zero_res;
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      quo <= quo_nx;
      rem <= rem_nx;
      if (last) div_result <= calc_res;
    end
  end
endmodule
